button_debouncer: RTL and testbench

//   Conditions the four raw, asynchronous direction push-buttons before they reach the

---
 rtl/button_debouncer_if.sv | 56 +++++
 rtl/button_debouncer.sv | 123 ++++++++++++
 tb/tb_button_debouncer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : button_debouncer_if                                         |
// | Brief    : Raw-button inputs and conditioned level outputs of the      |
// |            direction-button debouncer. BTN_PRESS_PULSE_EN adds the     |
// |            press_pulse[3:0] strobe = {down,up,right,left}.             |
// | Revision : 1.0                                                        |
// +------------------------------------------------------------------------+
interface button_debouncer_if;
    logic       left_raw;
    logic       right_raw;
    logic       up_raw;
    logic       down_raw;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       single;
`ifdef BTN_PRESS_PULSE_EN
    logic [3:0] press_pulse;
`endif

    // master drives the raw buttons; slave is the debouncer itself
    modport master (
        output left_raw,
        output right_raw,
        output up_raw,
        output down_raw,
        input  left,
        input  right,
        input  up,
        input  down,
        input  single
`ifdef BTN_PRESS_PULSE_EN
        ,
        input  press_pulse
`endif
    );

    modport slave (
        input  left_raw,
        input  right_raw,
        input  up_raw,
        input  down_raw,
        output left,
        output right,
        output up,
        output down,
        output single
`ifdef BTN_PRESS_PULSE_EN
        ,
        output press_pulse
`endif
    );
endinterface : button_debouncer_if
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : button_debouncer                                            |
// | Brief    : Two-flop synchroniser plus symmetric counter debounce per   |
// |            direction button, with a registered exactly-one-high flag.  |
// |            Optional macro BTN_PRESS_PULSE_EN adds a 1-cycle press      |
// |            strobe per button.                                          |
// | Revision : 1.0                                                        |
// +------------------------------------------------------------------------+
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  wire               clk,
    input  wire               reset,
    button_debouncer_if.slave bus
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               NUM_BTN    = 4;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Bit order everywhere: {down, up, right, left}
    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] w_stable_q;
    logic [NUM_BTN-1:0] w_stable_d;
    logic               single_q;
    logic               single_d;

    assign w_raw = {bus.down_raw, bus.up_raw, bus.right_raw, bus.left_raw};

    function automatic logic f_exactly_one(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
    endfunction

    // Plain back-to-back flops so the synthesis tool can treat them as a synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Any sample agreeing with the accepted level restarts the count
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync2_q[gi] != stable_q) begin
                if (cnt_q == c_CNT_LAST) begin
                    stable_d = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign w_stable_q[gi] = stable_q;
        assign w_stable_d[gi] = stable_d;
    end : g_btn

    // Built from next-state levels so it moves on the same edge as the outputs
    assign single_d = f_exactly_one(w_stable_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            single_q <= 1'b0;
        end else begin
            single_q <= single_d;
        end
    end

    assign bus.left   = w_stable_q[0];
    assign bus.right  = w_stable_q[1];
    assign bus.up     = w_stable_q[2];
    assign bus.down   = w_stable_q[3];
    assign bus.single = single_q;

`ifdef BTN_PRESS_PULSE_EN
    logic [NUM_BTN-1:0] stable_prev_q;
    logic [NUM_BTN-1:0] press_pulse_q;
    logic [NUM_BTN-1:0] press_pulse_d;

    // Rising edges only; a release never strobes
    assign press_pulse_d = w_stable_q & ~stable_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_q <= '0;
            press_pulse_q <= '0;
        end else begin
            stable_prev_q <= w_stable_q;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign bus.press_pulse = press_pulse_q;
`else
    // Level outputs only; no edge-detect state is built.
`endif

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_button_debouncer                                         |
// | Brief    : Directed scoreboard bench for button_debouncer with         |
// |            DEBOUNCE_CYCLES = 4; covers BTN_PRESS_PULSE_EN when defined.|
// | Revision : 1.0                                                        |
// +------------------------------------------------------------------------+
module tb_button_debouncer;

    localparam int DEBOUNCE_CYCLES = 4;
    // Raw driven at a falling edge is sampled on the next rising edge E;
    // the level moves after edge E+N+1, i.e. LAT falling edges after the drive.
    localparam int LAT = DEBOUNCE_CYCLES + 2;

    typedef struct {
        string      tag;
        int         cyc;
        bit         is_pulse;
        logic [4:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;
    logic [4:0] mon_obs;
    logic [4:0] out5;
    logic [7:0] bounce_pat;

    button_debouncer_if bif ();

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    assign out5 = {bif.left, bif.right, bif.up, bif.down, bif.single};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_out(input string tag, input int dc, input logic [4:0] v);
        sb.push_back('{tag, cyc + dc, 1'b0, v});
    endtask

`ifdef BTN_PRESS_PULSE_EN
    task automatic push_pulse(input string tag, input int dc, input logic [3:0] v);
        sb.push_back('{tag, cyc + dc, 1'b1, {1'b0, v}});
    endtask
`define PP(t, d, v) push_pulse(t, d, v);
`else
`define PP(t, d, v)
`endif

    task automatic set_raw(input logic l, input logic r, input logic u, input logic d);
        bif.left_raw  = l;
        bif.right_raw = r;
        bif.up_raw    = u;
        bif.down_raw  = d;
    endtask

    // Scoreboard: pop every entry due on this falling edge and compare
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            mon_e = sb[i];
            if (mon_e.cyc == cyc) begin
`ifdef BTN_PRESS_PULSE_EN
                mon_obs = mon_e.is_pulse ? {1'b0, bif.press_pulse} : out5;
`else
                mon_obs = out5;
`endif
                checks++;
                assert (mon_obs === mon_e.val) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b",
                           mon_e.tag, cyc, mon_obs, mon_e.val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bounce_pat = 8'b1111_0111;  // bit i is the value for cycle i: 1,1,1,0,1,1,1,1
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // Reset held 3 cycles with every button pressed
        set_raw(1'b1, 1'b1, 1'b1, 1'b1);
        push_out("rst_hold1", 1, 5'b00000);
        push_out("rst_hold2", 2, 5'b00000);
        push_out("rst_hold3", 3, 5'b00000);
        tick(3);
        reset = 1'b0;
        push_out("rst_rel_early", LAT - 1, 5'b00000);
        push_out("rst_rel_all",   LAT,     5'b11110);
        `PP("rst_pulse_early", LAT,     4'b0000)
        `PP("rst_pulse_all",   LAT + 1, 4'b1111)
        `PP("rst_pulse_end",   LAT + 2, 4'b0000)
        tick(LAT + 2);

        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        push_out("all_rel_early", LAT - 1, 5'b11110);
        push_out("all_rel",       LAT,     5'b00000);
        `PP("all_rel_pulse", LAT + 1, 4'b0000)
        tick(LAT + 2);

        // Clean press of up
        set_raw(1'b0, 1'b0, 1'b1, 1'b0);
        push_out("up_early", LAT - 1, 5'b00000);
        push_out("up_press", LAT,     5'b00101);
        `PP("up_pulse_early", LAT,     4'b0000)
        `PP("up_pulse",       LAT + 1, 4'b0100)
        `PP("up_pulse_end",   LAT + 2, 4'b0000)
        tick(LAT + 2);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        push_out("up_rel_early", LAT - 1, 5'b00101);
        push_out("up_rel",       LAT,     5'b00000);
        tick(LAT + 2);

        // Bounce on left: glitch at the 4th cycle restarts the count
        push_out("bnc_hold6", 6,  5'b00000);
        push_out("bnc_hold8", 8,  5'b00000);
        push_out("bnc_hold9", 9,  5'b00000);
        push_out("bnc_rise",  10, 5'b10001);
        `PP("bnc_pulse_early", 10, 4'b0000)
        `PP("bnc_pulse",       11, 4'b0001)
        `PP("bnc_pulse_end",   12, 4'b0000)
        for (int i = 0; i < 8; i++) begin
            bif.left_raw = bounce_pat[i];
            tick(1);
        end
        tick(6);

        // Swap left for right, then release right
        set_raw(1'b0, 1'b1, 1'b0, 1'b0);
        push_out("swap_early", LAT - 1, 5'b10001);
        push_out("swap",       LAT,     5'b01001);
        `PP("swap_pulse", LAT + 1, 4'b0010)
        tick(LAT + 2);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        push_out("right_rel_early", LAT - 1, 5'b01001);
        push_out("right_rel",       LAT,     5'b00000);
        `PP("right_rel_pulse0", LAT,     4'b0000)
        `PP("right_rel_pulse1", LAT + 1, 4'b0000)
        tick(LAT + 2);

        // Chord: left and down together
        set_raw(1'b1, 1'b0, 1'b0, 1'b1);
        push_out("chord_early", LAT - 1, 5'b00000);
        push_out("chord",       LAT,     5'b10010);
        `PP("chord_pulse", LAT + 1, 4'b1001)
        tick(LAT + 2);
        set_raw(1'b1, 1'b0, 1'b0, 1'b0);
        push_out("down_drop_early", LAT - 1, 5'b10010);
        push_out("down_drop",       LAT,     5'b10001);
        `PP("down_drop_pulse", LAT + 1, 4'b0000)
        tick(LAT + 2);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        push_out("left_drop", LAT, 5'b00000);
        tick(LAT + 2);

        // Reset two cycles after s2 sees up: count restarts from scratch
        set_raw(1'b0, 1'b0, 1'b1, 1'b0);
        push_out("mid_rst_in",     4,  5'b00000);
        push_out("mid_rst_noacc",  6,  5'b00000);
        push_out("mid_rst_early",  9,  5'b00000);
        push_out("mid_rst_accept", 10, 5'b00101);
        `PP("mid_rst_pulse0", 6,  4'b0000)
        `PP("mid_rst_pulse",  11, 4'b0100)
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(LAT + 4);
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick(LAT + 2);

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick(1);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
